// File: rtl/alu_host_driver.sv
// alu_host_driver
//   Host-side initiator for the sequential ALU. Takes one request on a
//   valid/ready port, strobes the ALU with BEGIN and the op code, streams
//   the operand bytes onto the ALU input bus, waits for END, assembles the
//   result from the ALU output bus and offers it on a valid/ready response
//   port.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_op[1:0]                00 add, 01 sub, 10 mul, 11 div
//   req_x[15:0], req_y[7:0]    operands (div: 16-bit dividend, 8-bit divisor)
//   resp_valid/resp_ready      response handshake, held until accepted
//   resp_data[15:0], resp_err  result; err on div-by-zero, protocol error, timeout
//   alu_begin, alu_op_code     ALU start strobe and op code
//   alu_inbus[7:0]             operand bytes to the ALU
//   alu_outbus[7:0], alu_end   result bytes and completion strobe from the ALU
//
// Build option
//   ALU_HOST_DRIVER_TIMEOUT_EN: adds an 8-bit watchdog that aborts WAIT after
//   TIMEOUT_CYCLES cycles without alu_end. Without it WAIT never times out.

module alu_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [7:0]  req_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  prev_q, prev_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        alu_begin_q, alu_begin_d;
  logic [1:0]  alu_op_code_q, alu_op_code_d;
  logic [7:0]  alu_inbus_q, alu_inbus_d;

  logic        accept;
  logic        div_zero;
  logic        is_div;
  logic [1:0]  last_idx;
  logic        timeout_hit;

  assign accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign div_zero = (req_op == 2'b11) && (req_y == 8'h00);
  assign is_div   = (op_q == 2'b11);
  assign last_idx = is_div ? 2'd2 : 2'd1;

`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;

  // Counter holds the number of WAIT cycles already spent; the abort fires
  // in the cycle that would make it reach TIMEOUT_CYCLES, and alu_end wins.
  assign timeout_hit = (state_q == S_WAIT) && (wd_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_WAIT) begin
      wd_d = wd_q + 8'd1;
    end else if (state_d == S_WAIT) begin
      wd_d = '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  function automatic logic [7:0] load_byte(input logic div, input logic [1:0] idx,
                                            input logic [15:0] x, input logic [7:0] y);
    logic [7:0] b;
    if (div) begin
      case (idx)
        2'd0:    b = x[15:8];
        2'd1:    b = x[7:0];
        default: b = y;
      endcase
    end else begin
      b = (idx == 2'd0) ? x[7:0] : y;
    end
    return b;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      alu_begin_q   <= 1'b0;
      alu_op_code_q <= '0;
      alu_inbus_q   <= '0;
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      alu_begin_q   <= alu_begin_d;
      alu_op_code_q <= alu_op_code_d;
      alu_inbus_q   <= alu_inbus_d;
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
      wd_q          <= wd_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = div_zero ? S_RESP : S_START;
      S_START: state_d = alu_end ? S_RESP : S_LOAD;
      S_LOAD: begin
        if (alu_end) begin
          state_d = S_RESP;
        end else if (cnt_q == last_idx) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT:  if (alu_end || timeout_hit) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; outputs follow the state being entered
  always_comb begin
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    alu_inbus_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = req_op;
          x_d  = req_x;
          y_d  = req_y;
          if (div_zero) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d = '0;
        if (alu_end) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end else begin
          alu_inbus_d = load_byte(is_div, 2'd0, x_q, y_q);
        end
      end
      S_LOAD: begin
        prev_d = '0;
        if (alu_end) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end else if (cnt_q != last_idx) begin
          cnt_d       = cnt_q + 2'd1;
          alu_inbus_d = load_byte(is_div, cnt_q + 2'd1, x_q, y_q);
        end
      end
      S_WAIT: begin
        // The ALU shows the high byte one cycle before END, so keep the
        // previous bus value around to pair with the END-cycle low byte.
        prev_d = alu_outbus;
        if (alu_end) begin
          resp_data_d = op_q[1] ? {prev_q, alu_outbus} : {8'h00, alu_outbus};
          resp_err_d  = 1'b0;
        end else if (timeout_hit) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase

    req_ready_d   = (state_d == S_IDLE);
    resp_valid_d  = (state_d == S_RESP);
    alu_begin_d   = (state_d == S_START);
    alu_op_code_d = (state_d inside {S_START, S_LOAD, S_WAIT}) ? op_d : 2'b00;
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign alu_begin   = alu_begin_q;
  assign alu_op_code = alu_op_code_q;
  assign alu_inbus   = alu_inbus_q;

endmodule
